// File: rtl/bloom_filter_query.sv
// Bloom filter membership query: hashes a 72-bit key into three 12-bit indices
// and probes the filter BRAM one bit at a time, stopping early on the first clear bit.
module bloom_filter_query #(
   parameter int BRAM_LAT = 1
) (
   input  logic        clka,
   input  logic        rst_n,
   input  logic [71:0] data_in,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        hit,
   output logic        bram_en,
   output logic [6:0]  bram_addr,
   input  logic [31:0] bram_dout
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HASH  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      CHECK = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state_r;
   logic [71:0]       key_r;
   logic [2:0][11:0]  h_r;
   logic [1:0]        p_r;

   logic [2:0][11:0]  hash_s;
   logic [11:0]       sum_s;
   logic [4:0]        cur_bit_s;
   logic [1:0]        nxt_p_s;
   logic [6:0]        nxt_addr_s;
   logic              probe_set_s;

   function automatic logic [11:0] rotl12(input logic [11:0] v, input int n);
      logic [11:0] r;
      r = (v << n) | (v >> (12 - n));
      return r;
   endfunction

   // Hash indices from the latched key; the 12-bit sum wraps modulo 4096 by width.
   always_comb begin
      hash_s = '0;
      sum_s  = 12'd0;
      for (int j = 0; j < 6; j++) begin
         hash_s[0] = hash_s[0] ^ key_r[12*j +: 12];
         sum_s     = sum_s + key_r[12*j +: 12];
         hash_s[2] = hash_s[2] ^ rotl12(key_r[12*j +: 12], j);
      end
      hash_s[1] = sum_s;
   end

   // Bit under test for the current probe and word address of the next probe.
   always_comb begin
      nxt_p_s = p_r + 2'd1;
      case (p_r)
         2'd0:    cur_bit_s = h_r[0][4:0];
         2'd1:    cur_bit_s = h_r[1][4:0];
         2'd2:    cur_bit_s = h_r[2][4:0];
         default: cur_bit_s = h_r[2][4:0];
      endcase
      case (nxt_p_s)
         2'd0:    nxt_addr_s = h_r[0][11:5];
         2'd1:    nxt_addr_s = h_r[1][11:5];
         2'd2:    nxt_addr_s = h_r[2][11:5];
         default: nxt_addr_s = h_r[2][11:5];
      endcase
      probe_set_s = bram_dout[cur_bit_s];
   end

   // Query FSM; outputs are registered on the transition into the state that owns them.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         key_r     <= 72'd0;
         h_r       <= '0;
         p_r       <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit       <= 1'b0;
         bram_en   <= 1'b0;
         bram_addr <= 7'd0;
      end else begin
         bram_en <= 1'b0;
         done    <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  key_r   <= data_in;
                  hit     <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= HASH;
               end
            end
            HASH: begin
               h_r       <= hash_s;
               p_r       <= 2'd0;
               bram_en   <= 1'b1;
               bram_addr <= hash_s[0][11:5];
               state_r   <= ISSUE;
            end
            ISSUE: begin
               state_r <= (BRAM_LAT == 2) ? WAIT : CHECK;
            end
            WAIT: begin
               state_r <= CHECK;
            end
            CHECK: begin
               if (!probe_set_s) begin
                  hit     <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else if (p_r == 2'd2) begin
                  hit     <= 1'b1;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  p_r       <= nxt_p_s;
                  bram_en   <= 1'b1;
                  bram_addr <= nxt_addr_s;
                  state_r   <= ISSUE;
               end
            end
            DONE: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bloom_filter_query.sv
// Bench for bloom_filter_query: one instance per BRAM latency, directed table,
// multi-cycle corner sequences and random queries against an arithmetic reference.
module tb_bloom_filter_query;

   logic clka = 1'b0;
   logic rst_n;
   always #5 clka = ~clka;

   logic [1:0]        st;
   logic [1:0][71:0]  din;
   logic [1:0][31:0]  dout;
   wire  [1:0]        busy, done, hit, en;
   wire  [1:0][6:0]   addr;
   logic [31:0]       mem [2][128];
   logic [31:0]       q1;

   bloom_filter_query #(.BRAM_LAT(1)) u_lat1 (
      .clka(clka), .rst_n(rst_n), .data_in(din[0]), .start(st[0]),
      .busy(busy[0]), .done(done[0]), .hit(hit[0]),
      .bram_en(en[0]), .bram_addr(addr[0]), .bram_dout(dout[0]));

   bloom_filter_query #(.BRAM_LAT(2)) u_lat2 (
      .clka(clka), .rst_n(rst_n), .data_in(din[1]), .start(st[1]),
      .busy(busy[1]), .done(done[1]), .hit(hit[1]),
      .bram_en(en[1]), .bram_addr(addr[1]), .bram_dout(dout[1]));

   // BRAM read ports: one register stage for latency 1, two for latency 2.
   always @(posedge clka) begin
      if (en[0]) dout[0] <= mem[0][addr[0]];
      q1      <= mem[1][addr[1]];
      dout[1] <= q1;
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference hash: slices taken as plain integers, sum reduced with %, rotate by shifts.
   function automatic logic [11:0] hidx(input logic [71:0] k, input int p);
      int x, sm, r, s;
      x = 0; sm = 0; r = 0;
      for (int j = 0; j < 6; j++) begin
         s  = int'(k[12*j +: 12]);
         x  = x ^ s;
         sm = sm + s;
         r  = r ^ (((s << j) | (s >> (12 - j))) & 32'h0000_0FFF);
      end
      if (p == 0) return x[11:0];
      else if (p == 1) return 12'(sm % 4096);
      else return r[11:0];
   endfunction

   function automatic void ref_query(input int d, input logic [71:0] k,
                                     output bit h, output int n);
      logic [11:0] idx;
      logic [31:0] w;
      h = 1'b1;
      n = 3;
      for (int p = 0; p < 3; p++) begin
         idx = hidx(k, p);
         w   = mem[d][idx[11:5]];
         if (w[idx[4:0]] == 1'b0) begin
            h = 1'b0;
            n = p + 1;
            return;
         end
      end
   endfunction

   function automatic logic [71:0] rand_key();
      logic [71:0] k;
      k = {8'($urandom), $urandom, $urandom};
      return k;
   endfunction

   // One query on instance d; spam keeps start high and scrambles data_in while busy.
   task automatic do_query(input int d, input logic [71:0] k, input bit spam, input string tag,
                           output int lat_o, output bit hit_o, output int reads_o,
                           output logic [6:0] last_addr_o);
      bit          eh;
      int          en_n, elat, lt, addr_bad, busy_bad, gap_bad, dn;
      logic [11:0] ei;
      lt = 1 + (d + 1);
      ref_query(d, k, eh, en_n);
      elat = 2 + en_n * lt;
      lat_o = 0; reads_o = 0; addr_bad = 0; busy_bad = 0; gap_bad = 0;
      last_addr_o = 7'd0;
      @(negedge clka);
      din[d] = k;
      st[d]  = 1'b1;
      @(posedge clka);
      #1;
      if (!spam) st[d] = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clka);
         if (spam) din[d] = rand_key();
         if (busy[d] !== 1'b1) busy_bad++;
         if (en[d] === 1'b1) begin
            ei = hidx(k, reads_o);
            if (addr[d] !== ei[11:5]) addr_bad++;
            if (c != 2 + reads_o * lt) gap_bad++;
            last_addr_o = addr[d];
            reads_o++;
         end
         if (done[d] === 1'b1) begin
            lat_o = c;
            break;
         end
      end
      hit_o = hit[d];
      chk({tag, " latency"}, 32'(lat_o), 32'(elat));
      chk({tag, " hit"}, {31'd0, hit_o}, {31'd0, eh});
      chk({tag, " reads"}, 32'(reads_o), 32'(en_n));
      chk({tag, " read addr"}, 32'(addr_bad), 32'd0);
      chk({tag, " read spacing"}, 32'(gap_bad), 32'd0);
      chk({tag, " busy during query"}, 32'(busy_bad), 32'd0);
      @(negedge clka);
      chk({tag, " idle after done"}, {29'd0, busy[d], done[d], en[d]}, 32'd0);
      chk({tag, " hit held"}, {31'd0, hit[d]}, {31'd0, eh});
      if (spam) begin
         @(negedge clka);
         chk({tag, " start after done accepted"}, {31'd0, busy[d]}, 32'd1);
         st[d] = 1'b0;
         dn = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clka);
            if (done[d] === 1'b1) dn++;
         end
         chk({tag, " second query one done"}, 32'(dn), 32'd1);
      end
   endtask

   typedef struct {
      int          d;
      logic [71:0] key;
      logic [6:0]  waddr;
      logic [31:0] wval;
      bit          exp_hit;
      int          exp_lat;
      int          exp_reads;
      logic [6:0]  exp_addr;
   } vec_t;

   vec_t        tbl [6];
   int          lat, rd, bad;
   bit          h;
   logic [6:0]  la;

   initial begin
      tbl[0] = '{0, 72'h0,    7'd0,   32'h0000_0000, 1'b0, 4,  1, 7'd0};
      tbl[1] = '{0, 72'h1,    7'd0,   32'h0000_0002, 1'b1, 8,  3, 7'd0};
      tbl[2] = '{0, 72'h1,    7'd0,   32'h0000_0001, 1'b0, 4,  1, 7'd0};
      tbl[3] = '{0, 72'h1000, 7'd0,   32'h0000_0002, 1'b0, 8,  3, 7'd0};
      tbl[4] = '{1, 72'hFFF,  7'd127, 32'h8000_0000, 1'b1, 11, 3, 7'd127};
      tbl[5] = '{1, 72'h0,    7'd0,   32'h0000_0000, 1'b0, 5,  1, 7'd0};

      st = 2'b00;
      din = '0;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 128; a++) mem[d][a] = 32'd0;
      #1;
      chk("reset outputs", {22'd0, busy, done, hit, en}, 32'd0);
      chk("reset addr", {18'd0, addr}, 32'd0);
      repeat (3) @(posedge clka);
      @(negedge clka);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         for (int a = 0; a < 128; a++) mem[tbl[i].d][a] = 32'd0;
         mem[tbl[i].d][tbl[i].waddr] = tbl[i].wval;
         do_query(tbl[i].d, tbl[i].key, 1'b0, $sformatf("vec%0d", i), lat, h, rd, la);
         chk($sformatf("vec%0d table latency", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("vec%0d table hit", i), {31'd0, h}, {31'd0, tbl[i].exp_hit});
         chk($sformatf("vec%0d table reads", i), 32'(rd), 32'(tbl[i].exp_reads));
         chk($sformatf("vec%0d table addr", i), {25'd0, la}, {25'd0, tbl[i].exp_addr});
      end

      // start held high through a full-hit query, with data_in scrambled in flight.
      for (int a = 0; a < 128; a++) mem[0][a] = 32'd0;
      mem[0][0] = 32'h0000_0002;
      do_query(0, 72'h1, 1'b1, "spam", lat, h, rd, la);

      // Reset during probe 1 WAIT on the latency-2 instance.
      for (int a = 0; a < 128; a++) mem[1][a] = 32'd0;
      mem[1][127] = 32'h8000_0000;
      @(negedge clka);
      din[1] = 72'hFFF;
      st[1]  = 1'b1;
      @(posedge clka);
      #1;
      st[1] = 1'b0;
      repeat (6) @(negedge clka);
      rst_n = 1'b0;
      #1;
      chk("mid-query reset outputs", {28'd0, busy[1], done[1], hit[1], en[1]}, 32'd0);
      chk("mid-query reset addr", {25'd0, addr[1]}, 32'd0);
      bad = 0;
      repeat (2) begin
         @(negedge clka);
         if (done[1] !== 1'b0 || en[1] !== 1'b0 || busy[1] !== 1'b0) bad++;
      end
      rst_n = 1'b1;
      repeat (15) begin
         @(negedge clka);
         if (done[1] !== 1'b0 || en[1] !== 1'b0 || busy[1] !== 1'b0) bad++;
      end
      chk("aborted query silent", 32'(bad), 32'd0);
      do_query(1, 72'hFFF, 1'b0, "after reset", lat, h, rd, la);

      // Random keys over dense random filter contents.
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0)
            for (int d = 0; d < 2; d++)
               for (int a = 0; a < 128; a++) mem[d][a] = $urandom | $urandom | $urandom;
         do_query(i % 2, rand_key(), 1'b0, $sformatf("rand%0d", i), lat, h, rd, la);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/bloom_filter_query.md
# bloom_filter_query

Membership-query engine for the BRAM-backed Bloom filter. It takes a 72-bit key, computes the same three 12-bit hash indices the insert path uses, and probes the 4096-bit filter array through the BRAM read port. It returns hit (possibly present) or miss (definitely absent), ending early on the first zero bit. It sits on the read side of the filter BRAM, opposite the insert engine, and exposes the same start/done handshake.

## Interface
- BRAM_LAT, 1, BRAM read latency in cycles from bram_en to valid bram_dout; legal values 1 or 2.

- clka  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  72  query key; sampled only on the cycle start is accepted.
- start  in  1  query request; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; query result is valid.
- hit  out  1  1 = all probed bits set, 0 = miss; held from done until the next accepted start.
- bram_en  out  1  read enable, one cycle per probe.
- bram_addr  out  7  word address, h[11:5].
- bram_dout  in  32  read data, valid BRAM_LAT cycles after bram_en.

## Operation
- Key slices: s_j = data_in[12j+11:12j], for j = 0..5.
- Hash indices, all 12 bits:
  - h0 = s0^s1^s2^s3^s4^s5.
  - h1 = (s0+s1+s2+s3+s4+s5) mod 4096.
  - h2 = XOR over j of rotl12(s_j, j).
- Probe p reads word h_p[11:5] and tests bit h_p[4:0] of bram_dout.
- FSM states:
  - IDLE: start=1 latches data_in, clears hit, and goes to HASH.
  - HASH (1 cycle): registers h0..h2, sets p=0, and goes to ISSUE.
  - ISSUE (1 cycle): bram_en=1 and bram_addr=h_p[11:5]. Goes to WAIT if BRAM_LAT=2, else CHECK.
  - WAIT (1 cycle, only when BRAM_LAT=2): goes to CHECK.
  - CHECK: tests the bit.
    - Bit 0: hit<=0, go to DONE.
    - Bit 1 and p=2: hit<=1, go to DONE.
    - Otherwise: p<=p+1, go to ISSUE.
  - DONE (1 cycle): done=1, go to IDLE.
- start is ignored in all states other than IDLE, including DONE. No queuing: a start during busy is lost.
- bram_en is 0 outside ISSUE. bram_addr holds its last value when bram_en=0.
- Duplicate indices are still probed separately; there is no de-duplication.
- The block never writes BRAM.

## Timing
- Reset (async assert, synchronous release): state=IDLE, busy=0, done=0, hit=0, bram_en=0, bram_addr=0, p=0.
- Reset mid-query: the query is aborted immediately, with no done pulse and no further bram_en.
- Latency is counted from the rising edge that samples start=1 in IDLE to the cycle done=1:
  - Full hit: 2 + 3*(1+BRAM_LAT) cycles, which is 8 for BRAM_LAT=1 and 11 for BRAM_LAT=2.
  - Miss at probe p: 2 + (p+1)*(1+BRAM_LAT) cycles.
- busy rises the cycle after the accepting edge and falls the cycle after done.
- Back-to-back queries: the earliest next start is the cycle after done, i.e. the first IDLE cycle.
- Exactly 1 to 3 bram_en pulses per query, spaced 1+BRAM_LAT cycles apart.
- data_in changes after acceptance have no effect on the query in flight.

## Test plan
- BRAM all zero, data_in=72'h0, BRAM_LAT=1:
  - One read, at addr 0.
  - done at cycle 4 with hit=0.
- Word0=32'h0000_0002, data_in=72'h1 (h=1,1,1):
  - Reads addr 0 once.
  - Bit 1 set: miss is wrong, so expect three reads, then done at cycle 8 with hit=1.
  - Repeat with word0=32'h1: miss at cycle 4.
- Word0=32'h0000_0002, data_in=72'h1000 (h=1,1,2):
  - Probes 0 and 1 pass; probe 2 (bit 2) fails.
  - done at cycle 8 with hit=0, after three reads of addr 0.
- Word127=32'h8000_0000, data_in=72'hFFF (h=FFF,FFF,FFF), BRAM_LAT=2:
  - Three reads of addr 127.
  - done at cycle 11 with hit=1.
- Pulse start every cycle while busy:
  - Only the first query runs and exactly one done fires.
  - A start in the cycle after done is accepted.
- Assert rst_n=0 during the WAIT/CHECK of probe 1:
  - All outputs 0 immediately; no done pulse.
  - A new query after release completes normally.
